// File: rtl/pe_vec_acc_if.sv
// pe_vec_acc_if -- operand stream, control and read-back bundle for pe_vec_acc.
//
// Signals (direction seen from the master, i.e. the array controller):
//   clear      out  synchronous clear of accumulator, slots, write pointer, flags
//   in_valid   out  operand beat valid
//   in_ready   in   PE accepts a beat this cycle
//   in_pixel   out  unsigned pixel operand (DATA_W)
//   in_filt    out  unsigned filter operand (DATA_W)
//   in_last    out  beat closes the current window
//   in_slot    out  result slot of the window, taken on the last beat
//   flush      out  commit a partially filled result vector
//   rd_en      out  read strobe
//   rd_adr     out  read address
//   rd_data    in   registered read data, slot k at [k*OUT_W +: OUT_W]
//   wr_count   in   number of committed words
//   mem_full   in   result memory is full
interface pe_vec_acc_if #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 8,
  parameter int NUM_FILT  = 4,
  parameter int MEM_DEPTH = 128
);
  localparam int SLOT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int ADR_W  = $clog2(MEM_DEPTH);
  localparam int CNT_W  = $clog2(MEM_DEPTH + 1);
  localparam int WORD_W = NUM_FILT * OUT_W;

  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic [DATA_W-1:0] in_filt;
  logic              in_last;
  logic [SLOT_W-1:0] in_slot;
  logic              flush;
  logic              rd_en;
  logic [ADR_W-1:0]  rd_adr;
  logic [WORD_W-1:0] rd_data;
  logic [CNT_W-1:0]  wr_count;
  logic              mem_full;

  modport master (
    output clear, in_valid, in_pixel, in_filt, in_last, in_slot, flush, rd_en, rd_adr,
    input  in_ready, rd_data, wr_count, mem_full
  );

  modport slave (
    input  clear, in_valid, in_pixel, in_filt, in_last, in_slot, flush, rd_en, rd_adr,
    output in_ready, rd_data, wr_count, mem_full
  );
endinterface

// File: rtl/pe_vec_acc.sv
// pe_vec_acc -- convolution-array processing element.
// Accumulates pixel*filter products over a window, scales and saturates the
// window sum into one of NUM_FILT result slots, and commits the packed slot
// vector to a local result memory once every slot is filled (or on flush).
// Results are drained through a registered read port.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   pe_vec_acc_if.slave: operand stream, clear/flush, read port, status
module pe_vec_acc #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 0,
  parameter int SAT_EN    = 1,
  parameter int NUM_FILT  = 4,
  parameter int MEM_DEPTH = 128
) (
  input logic         clk,
  input logic         rst,
  pe_vec_acc_if.slave bus
);
  localparam int SLOT_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int ADR_W  = $clog2(MEM_DEPTH);
  localparam int CNT_W  = $clog2(MEM_DEPTH + 1);
  localparam int WORD_W = NUM_FILT * OUT_W;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  typedef enum logic [1:0] {ST_ACC, ST_STORE, ST_COMMIT, ST_FULL} state_t;

  state_t              state_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [SLOT_W-1:0]   slot_sel_reg;
  logic [NUM_FILT-1:0] slot_vld_reg;
  logic [OUT_W-1:0]    slots_reg [NUM_FILT];
  logic [CNT_W-1:0]    wr_count_reg;
  logic                in_ready_reg;
  logic                mem_full_reg;
  logic [WORD_W-1:0]   rd_data_reg;
  logic [WORD_W-1:0]   mem [MEM_DEPTH];

  logic                xfer;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      acc_sum;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W-1:0]    scaled;
  logic [OUT_W-1:0]    slot_val;
  logic [NUM_FILT-1:0] slot_hit;
  logic [WORD_W-1:0]   packed_word;
  logic                rd_adr_ok;
  logic                commit_we;

  assign xfer     = bus.in_valid & in_ready_reg;
  assign prod     = (2*DATA_W)'(bus.in_pixel) * (2*DATA_W)'(bus.in_filt);
  // One extra bit catches accumulator overflow for the clamp.
  assign acc_sum  = {1'b0, acc_reg} + (ACC_W+1)'(prod);
  assign acc_next = ((SAT_EN != 0) && acc_sum[ACC_W]) ? ACC_MAX : acc_sum[ACC_W-1:0];
  assign scaled   = acc_reg >> SHIFT;
  assign slot_val = ((SAT_EN != 0) && ((scaled >> OUT_W) != '0)) ? OUT_MAX : scaled[OUT_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_FILT; gi++) begin : g_slot
      if (NUM_FILT == 1) begin : g_single
        // A single-slot PE fills its only slot on every window.
        assign slot_hit[gi] = 1'b1;
      end else begin : g_multi
        assign slot_hit[gi] = (slot_sel_reg == SLOT_W'(gi));
      end
      assign packed_word[gi*OUT_W +: OUT_W] = slot_vld_reg[gi] ? slots_reg[gi] : '0;
    end

    if ((1 << ADR_W) == MEM_DEPTH) begin : g_adr_full
      assign rd_adr_ok = 1'b1;
    end else begin : g_adr_part
      assign rd_adr_ok = (bus.rd_adr < ADR_W'(MEM_DEPTH));
    end
  endgenerate

  assign commit_we = (state_reg == ST_COMMIT) && !bus.clear;

  // Result memory: plain synchronous write, no reset, so contents survive rst/clear.
  always_ff @(posedge clk) begin
    if (commit_we) mem[wr_count_reg[ADR_W-1:0]] <= packed_word;
  end

  // Read register; a same-cycle commit to the same address yields the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rd_data_reg <= '0;
    else if (bus.clear) rd_data_reg <= '0;
    else if (bus.rd_en) rd_data_reg <= rd_adr_ok ? mem[bus.rd_adr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_ACC;
      acc_reg      <= '0;
      slot_sel_reg <= '0;
      slot_vld_reg <= '0;
      for (int i = 0; i < NUM_FILT; i++) slots_reg[i] <= '0;
      wr_count_reg <= '0;
      in_ready_reg <= 1'b1;
      mem_full_reg <= 1'b0;
    end else if (bus.clear) begin
      state_reg    <= ST_ACC;
      acc_reg      <= '0;
      slot_sel_reg <= '0;
      slot_vld_reg <= '0;
      for (int i = 0; i < NUM_FILT; i++) slots_reg[i] <= '0;
      wr_count_reg <= '0;
      in_ready_reg <= 1'b1;
      mem_full_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_ACC: begin
          if (xfer) acc_reg <= acc_next;
          // A closing beat takes precedence over a coincident flush.
          if (xfer && bus.in_last) begin
            slot_sel_reg <= bus.in_slot;
            state_reg    <= ST_STORE;
            in_ready_reg <= 1'b0;
          end else if (bus.flush && (|slot_vld_reg)) begin
            state_reg    <= ST_COMMIT;
            in_ready_reg <= 1'b0;
          end
        end
        ST_STORE: begin
          for (int i = 0; i < NUM_FILT; i++) begin
            if (slot_hit[i]) slots_reg[i] <= slot_val;
          end
          slot_vld_reg <= slot_vld_reg | slot_hit;
          acc_reg      <= '0;
          if (&(slot_vld_reg | slot_hit)) begin
            state_reg <= ST_COMMIT;
          end else begin
            state_reg    <= ST_ACC;
            in_ready_reg <= 1'b1;
          end
        end
        ST_COMMIT: begin
          wr_count_reg <= wr_count_reg + CNT_W'(1);
          slot_vld_reg <= '0;
          for (int i = 0; i < NUM_FILT; i++) slots_reg[i] <= '0;
          if (wr_count_reg == CNT_W'(MEM_DEPTH - 1)) begin
            state_reg    <= ST_FULL;
            mem_full_reg <= 1'b1;
          end else begin
            state_reg    <= ST_ACC;
            in_ready_reg <= 1'b1;
          end
        end
        ST_FULL: begin
          // Parked until rst or clear.
        end
        default: begin
          state_reg    <= ST_ACC;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.mem_full = mem_full_reg;
  assign bus.wr_count = wr_count_reg;
  assign bus.rd_data  = rd_data_reg;
endmodule

// File: tb/tb_pe_vec_acc.sv
module tb_pe_vec_acc;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: default parameters ----------------
  pe_vec_acc_if ifa ();
  pe_vec_acc dut_a (.clk(clk), .rst(rst), .bus(ifa));

  // ---------------- instances B: NUM_FILT=1, MEM_DEPTH=4 ----------
  // gi: 0 -> SAT=1 SHIFT=0, 1 -> SAT=0 SHIFT=0, 2 -> SAT=1 SHIFT=8, 3 -> SAT=0 SHIFT=8
  logic       b_clear, b_valid, b_last, b_rd_en;
  logic [7:0] b_pixel, b_filt;
  logic [1:0] b_rd_adr;
  logic [7:0] b_rd    [4];
  logic [2:0] b_cnt   [4];
  logic       b_full  [4];
  logic       b_ready [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_b
      pe_vec_acc_if #(.NUM_FILT(1), .MEM_DEPTH(4)) ifb ();
      assign ifb.clear    = b_clear;
      assign ifb.in_valid = b_valid;
      assign ifb.in_pixel = b_pixel;
      assign ifb.in_filt  = b_filt;
      assign ifb.in_last  = b_last;
      assign ifb.in_slot  = 1'b0;
      assign ifb.flush    = 1'b0;
      assign ifb.rd_en    = b_rd_en;
      assign ifb.rd_adr   = b_rd_adr;
      assign b_rd[gi]     = ifb.rd_data;
      assign b_cnt[gi]    = ifb.wr_count;
      assign b_full[gi]   = ifb.mem_full;
      assign b_ready[gi]  = ifb.in_ready;
      pe_vec_acc #(
        .SHIFT((gi >= 2) ? 8 : 0),
        .SAT_EN((gi % 2 == 0) ? 1 : 0),
        .NUM_FILT(1),
        .MEM_DEPTH(4)
      ) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    end
  endgenerate

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  longint      m_acc;
  int          m_slot [4];
  bit          m_vld  [4];
  logic [31:0] m_mem  [128];
  int          m_cnt;
  bit          m_committed;

  task automatic m_reset();
    m_acc = 0;
    m_cnt = 0;
    for (int k = 0; k < 4; k++) begin m_slot[k] = 0; m_vld[k] = 0; end
  endtask

  task automatic m_commit();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) if (m_vld[k]) w[k*8 +: 8] = 8'(m_slot[k]);
    m_mem[m_cnt] = w;
    m_cnt++;
    for (int k = 0; k < 4; k++) begin m_slot[k] = 0; m_vld[k] = 0; end
    m_committed = 1;
  endtask

  task automatic m_beat(input int p, input int f, input bit last, input int slot);
    longint r;
    bit all;
    m_committed = 0;
    m_acc = m_acc + longint'(p) * longint'(f);
    if (m_acc > 64'd16777215) m_acc = 64'd16777215;
    if (last) begin
      r = (m_acc > 255) ? 255 : m_acc;
      m_slot[slot] = int'(r);
      m_vld[slot]  = 1;
      m_acc        = 0;
      all = 1;
      for (int k = 0; k < 4; k++) all = all & m_vld[k];
      if (all) m_commit();
    end
  endtask

  function automatic logic [7:0] bexp(input int i, input longint sum);
    longint r;
    r = (i >= 2) ? (sum / 256) : sum;
    if ((i % 2 == 0) && r > 255) r = 255;
    return 8'(r % 256);
  endfunction

  // ---------------- drivers (all start and end on a falling edge) ----------------
  task automatic a_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic a_send(input int p, input int f, input bit last, input int slot, output int stalls);
    stalls = 0;
    ifa.in_valid = 1'b1;
    ifa.in_pixel = 8'(p);
    ifa.in_filt  = 8'(f);
    ifa.in_last  = last;
    ifa.in_slot  = 2'(slot);
    while (ifa.in_ready !== 1'b1 && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 20) begin
      check("a_beat_timeout", 64'(ifa.in_ready), 64'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
      m_beat(p, f, last, slot);
    end
  endtask

  task automatic a_idle();
    ifa.in_valid = 1'b0;
    ifa.in_last  = 1'b0;
  endtask

  task automatic a_flush();
    int g;
    bit any;
    g = 0;
    while (ifa.in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    ifa.flush = 1'b1;
    @(negedge clk);
    ifa.flush = 1'b0;
    any = 0;
    for (int k = 0; k < 4; k++) any = any | m_vld[k];
    if (any) m_commit();
  endtask

  task automatic a_read(input int adr, input logic [31:0] exp, input string tag);
    ifa.rd_en  = 1'b1;
    ifa.rd_adr = 7'(adr);
    @(negedge clk);
    ifa.rd_en  = 1'b0;
    check(tag, 64'(ifa.rd_data), 64'(exp));
  endtask

  task automatic b_send(input int p, input int f, input bit last);
    int g;
    g = 0;
    b_valid = 1'b1; b_pixel = 8'(p); b_filt = 8'(f); b_last = last;
    while (b_ready[0] !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) check("b_beat_timeout", 64'(b_ready[0]), 64'd1);
    else begin @(posedge clk); @(negedge clk); end
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic b_read(input int adr);
    b_rd_en  = 1'b1;
    b_rd_adr = 2'(adr);
    @(negedge clk);
    b_rd_en  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, exp_st, len, slot, p, f;
    longint bsum [4];

    rst = 1'b1;
    ifa.clear = 0; ifa.in_valid = 0; ifa.in_pixel = 0; ifa.in_filt = 0; ifa.in_last = 0;
    ifa.in_slot = 0; ifa.flush = 0; ifa.rd_en = 0; ifa.rd_adr = 0;
    b_clear = 0; b_valid = 0; b_last = 0; b_rd_en = 0; b_pixel = 0; b_filt = 0; b_rd_adr = 0;
    m_reset();
    a_wait(2);
    rst = 1'b0;
    a_wait(1);

    // Reset state
    check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    check("rst_wr_count", 64'(ifa.wr_count), 64'd0);
    check("rst_mem_full", 64'(ifa.mem_full), 64'd0);
    check("rst_rd_data",  64'(ifa.rd_data),  64'd0);

    // Four windows fill one vector
    a_send(2, 5, 0, 0, st); a_send(3, 5, 0, 0, st); a_send(4, 5, 1, 0, st);
    a_send(1, 1, 1, 1, st);
    a_send(1, 2, 1, 2, st);
    a_send(1, 3, 1, 3, st);
    a_idle();
    a_wait(3);
    check("t1_wr_count", 64'(ifa.wr_count), 64'(m_cnt));
    a_read(0, 32'h0302012D, "t1_word");

    // Partial vector + flush
    ifa.clear = 1'b1; a_wait(1); ifa.clear = 1'b0;
    m_reset();
    check("clr_wr_count", 64'(ifa.wr_count), 64'd0);
    a_send(7, 1, 1, 0, st);
    a_send(3, 3, 1, 2, st);
    a_idle();
    a_flush();
    a_wait(2);
    check("t4_wr_count", 64'(ifa.wr_count), 64'd1);
    a_read(0, 32'h00090007, "t4_flush_word");
    a_flush();
    a_wait(2);
    check("t4_empty_flush", 64'(ifa.wr_count), 64'(m_cnt));

    // Saturation/shift variants and memory-full behaviour on the B instances
    b_send(255, 255, 0);
    b_send(255, 255, 1);
    a_wait(3);
    b_read(0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_cnt_%0d", i), 64'(b_cnt[i]), 64'd1);
      check($sformatf("t2_word_%0d", i), 64'(b_rd[i]), 64'(bexp(i, 130050)));
    end
    b_send(20, 15, 1);
    b_send(40, 15, 1);
    a_wait(3);
    for (int i = 0; i < 4; i++) check($sformatf("t3_notfull_%0d", i), 64'(b_full[i]), 64'd0);
    b_send(50, 20, 1);
    a_wait(3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_full_%0d", i), 64'(b_full[i]), 64'd1);
      check($sformatf("t3_cnt4_%0d", i), 64'(b_cnt[i]), 64'd4);
    end
    b_valid = 1'b1; b_pixel = 8'd9; b_filt = 8'd9; b_last = 1'b1;
    a_wait(5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_stall_%0d", i), 64'(b_ready[i]), 64'd0);
      check($sformatf("t3_cnt_hold_%0d", i), 64'(b_cnt[i]), 64'd4);
    end
    b_valid = 1'b0; b_last = 1'b0;
    b_clear = 1'b1; a_wait(1); b_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_clr_cnt_%0d", i), 64'(b_cnt[i]), 64'd0);
      check($sformatf("t3_clr_rdy_%0d", i), 64'(b_ready[i]), 64'd1);
      check($sformatf("t3_clr_full_%0d", i), 64'(b_full[i]), 64'd0);
    end
    b_read(0);
    for (int i = 0; i < 4; i++) check($sformatf("t3_keep0_%0d", i), 64'(b_rd[i]), 64'(bexp(i, 130050)));
    b_read(3);
    for (int i = 0; i < 4; i++) check($sformatf("t3_keep3_%0d", i), 64'(b_rd[i]), 64'(bexp(i, 1000)));

    // Reset in the middle of a window
    a_send(100, 100, 0, 1, st);
    a_send(50, 50, 0, 1, st);
    a_idle();
    #2 rst = 1'b1;
    a_wait(1);
    rst = 1'b0;
    m_acc = 0; m_cnt = 0;
    for (int k = 0; k < 4; k++) begin m_slot[k] = 0; m_vld[k] = 0; end
    a_wait(1);
    check("t5_in_ready", 64'(ifa.in_ready), 64'd1);
    check("t5_wr_count", 64'(ifa.wr_count), 64'd0);
    a_read(0, 32'h00090007, "t5_mem_kept");
    a_send(3, 3, 1, 0, st);
    a_idle();
    a_flush();
    a_wait(2);
    a_read(0, 32'h00000009, "t5_no_residue");

    // Back-to-back random windows with in_valid held high
    ifa.clear = 1'b1; a_wait(1); ifa.clear = 1'b0;
    m_acc = 0; m_cnt = 0;
    for (int k = 0; k < 4; k++) begin m_slot[k] = 0; m_vld[k] = 0; end
    exp_st = 0;
    for (int w = 0; w < 40; w++) begin
      len  = $urandom_range(1, 4);
      slot = $urandom_range(0, 3);
      for (int b = 0; b < len; b++) begin
        p = $urandom_range(0, 15);
        f = $urandom_range(0, 7);
        a_send(p, f, (b == len - 1), slot, st);
        check($sformatf("t6_stall_w%0d_b%0d", w, b), 64'(st), 64'((b == 0) ? exp_st : 0));
      end
      exp_st = m_committed ? 2 : 1;
    end
    a_idle();
    a_flush();
    a_wait(3);
    check("t6_wr_count", 64'(ifa.wr_count), 64'(m_cnt));
    for (int i = 0; i < m_cnt; i++) a_read(i, m_mem[i], $sformatf("t6_word_%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
